// File: rtl/decode_stage.sv
// RV32I/M decode stage: combinational decode of the incoming word, registered into a
// two-entry (main + skid) output buffer with valid/ready handshakes and synchronous flush.
module decode_stage #(
   parameter int unsigned XLEN         = 32,
   parameter bit          ENABLE_M     = 1'b1,
   parameter bit          ENABLE_FENCE = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      op_type,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] out_pc,
   output logic            illegal
);

   // op_type encoding; LUI must stay 0 so the reset bundle reads as LUI
   localparam logic [3:0] OP_LUI     = 4'd0;
   localparam logic [3:0] OP_AUIPC   = 4'd1;
   localparam logic [3:0] OP_JAL     = 4'd2;
   localparam logic [3:0] OP_JALR    = 4'd3;
   localparam logic [3:0] OP_BRANCH  = 4'd4;
   localparam logic [3:0] OP_LOAD    = 4'd5;
   localparam logic [3:0] OP_STORE   = 4'd6;
   localparam logic [3:0] OP_OPIMM   = 4'd7;
   localparam logic [3:0] OP_OP      = 4'd8;
   localparam logic [3:0] OP_MISCMEM = 4'd9;
   localparam logic [3:0] OP_SYSTEM  = 4'd10;

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

   typedef struct packed {
      logic [3:0]      op;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [2:0]      f3;
      logic [6:0]      f7;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic            ill;
   } bundle_t;

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_j;
   logic [31:0] imm_u;

   assign opc   = instr[6:0];
   assign f3    = instr[14:12];
   assign f7    = instr[31:25];
   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};

   bundle_t     dec;
   logic        dec_ill;
   logic [31:0] dec_imm32;

   always_comb begin
      dec       = '0;
      dec_ill   = 1'b0;
      dec_imm32 = '0;
      case (opc)
         OPC_LUI: begin
            dec.op    = OP_LUI;
            dec.rd    = instr[11:7];
            dec_imm32 = imm_u;
         end
         OPC_AUIPC: begin
            dec.op    = OP_AUIPC;
            dec.rd    = instr[11:7];
            dec_imm32 = imm_u;
         end
         OPC_JAL: begin
            dec.op    = OP_JAL;
            dec.rd    = instr[11:7];
            dec_imm32 = imm_j;
         end
         OPC_JALR: begin
            dec.op    = OP_JALR;
            dec.rd    = instr[11:7];
            dec.rs1   = instr[19:15];
            dec.f3    = f3;
            dec_imm32 = imm_i;
            dec_ill   = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            dec.op    = OP_BRANCH;
            dec.rs1   = instr[19:15];
            dec.rs2   = instr[24:20];
            dec.f3    = f3;
            dec_imm32 = imm_b;
            dec_ill   = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OPC_LOAD: begin
            dec.op    = OP_LOAD;
            dec.rd    = instr[11:7];
            dec.rs1   = instr[19:15];
            dec.f3    = f3;
            dec_imm32 = imm_i;
            dec_ill   = (f3 == 3'b011) || (f3[2:1] == 2'b11);
         end
         OPC_STORE: begin
            dec.op    = OP_STORE;
            dec.rs1   = instr[19:15];
            dec.rs2   = instr[24:20];
            dec.f3    = f3;
            dec_imm32 = imm_s;
            dec_ill   = (f3 > 3'b010);
         end
         OPC_OPIMM: begin
            dec.op    = OP_OPIMM;
            dec.rd    = instr[11:7];
            dec.rs1   = instr[19:15];
            dec.f3    = f3;
            dec_imm32 = imm_i;
            // shifts carry funct7 in the upper immediate bits; only SRAI may set bit 30
            if (f3 == 3'b001 || f3 == 3'b101) begin
               dec.f7  = f7;
               dec_ill = !((f7 == 7'b0000000) || (f7 == 7'b0100000 && f3 == 3'b101));
            end
         end
         OPC_OP: begin
            dec.op  = OP_OP;
            dec.rd  = instr[11:7];
            dec.rs1 = instr[19:15];
            dec.rs2 = instr[24:20];
            dec.f3  = f3;
            dec.f7  = f7;
            dec_ill = !((f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) ||
                        (f7 == 7'b0000001 && ENABLE_M));
         end
         OPC_MISCMEM: begin
            dec.op  = OP_MISCMEM;
            dec.rd  = instr[11:7];
            dec.rs1 = instr[19:15];
            dec.f3  = f3;
            dec_ill = !ENABLE_FENCE;
         end
         OPC_SYSTEM: begin
            dec.op  = OP_SYSTEM;
            dec.rd  = instr[11:7];
            dec.rs1 = instr[19:15];
            dec.f3  = f3;
         end
         default: dec_ill = 1'b1;
      endcase
      dec.imm       = {XLEN{dec_imm32[31]}};
      dec.imm[31:0] = dec_imm32;
      if (dec_ill) begin
         dec     = '0;
         dec.op  = OP_SYSTEM;
         dec.ill = 1'b1;
      end
      dec.pc = in_pc;
   end

   bundle_t main_q, main_d;
   bundle_t skid_q, skid_d;
   logic    main_valid_q, main_valid_d;
   logic    skid_valid_q, skid_valid_d;
   logic    in_fire;
   logic    out_fire;

   assign in_ready = !skid_valid_q;
   assign in_fire  = in_valid && in_ready && !flush;
   assign out_fire = main_valid_q && out_ready;

   // skid is only ever occupied while main is full, so FIFO order falls out naturally
   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_fire) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end else begin
            main_d       = in_fire ? dec : main_q;
            main_valid_d = in_fire;
         end
      end else if (in_fire) begin
         if (main_valid_q) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
         end else begin
            main_d       = dec;
            main_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign out_valid = main_valid_q;
   assign op_type   = main_q.op;
   assign rs1       = main_q.rs1;
   assign rs2       = main_q.rs2;
   assign rd        = main_q.rd;
   assign funct3    = main_q.f3;
   assign funct7    = main_q.f7;
   assign imm       = main_q.imm;
   assign out_pc    = main_q.pc;
   assign illegal   = main_q.ill;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed decode table, backpressure/flush/reset sequences,
// and a randomized run against a queue-based reference model.
module tb_decode_stage;

   localparam logic [3:0] T_LUI = 4'd0, T_AUIPC = 4'd1, T_JAL = 4'd2, T_JALR = 4'd3,
                          T_BRANCH = 4'd4, T_LOAD = 4'd5, T_STORE = 4'd6, T_OPIMM = 4'd7,
                          T_OP = 4'd8, T_MISCMEM = 4'd9, T_SYSTEM = 4'd10;

   typedef struct packed {
      logic [3:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [31:0] w;
      exp_t        e;
      logic        ill_m0;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] instr = '0;
   logic [31:0] in_pc = '0;
   logic        out_ready = 1'b0;
   logic        in_ready, out_valid, illegal;
   logic [3:0]  op_type;
   logic [4:0]  rs1, rs2, rd;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm, out_pc;

   logic        m0_in_ready, m0_out_valid, m0_illegal;
   logic [3:0]  m0_op_type;
   logic [4:0]  m0_rs1, m0_rs2, m0_rd;
   logic [2:0]  m0_funct3;
   logic [6:0]  m0_funct7;
   logic [31:0] m0_imm, m0_out_pc;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ENABLE_FENCE(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .op_type(op_type), .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3), .funct7(funct7),
      .imm(imm), .out_pc(out_pc), .illegal(illegal));

   decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ENABLE_FENCE(1'b0)) dut_m0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(m0_in_ready),
      .instr(instr), .in_pc(in_pc), .out_valid(m0_out_valid), .out_ready(out_ready),
      .op_type(m0_op_type), .rs1(m0_rs1), .rs2(m0_rs2), .rd(m0_rd), .funct3(m0_funct3),
      .funct7(m0_funct7), .imm(m0_imm), .out_pc(m0_out_pc), .illegal(m0_illegal));

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t dut_bundle();
      exp_t b;
      b = '{op: op_type, rd: rd, rs1: rs1, rs2: rs2, f3: funct3, f7: funct7,
            imm: imm, pc: out_pc, ill: illegal};
      return b;
   endfunction

   function automatic exp_t mk(input logic [3:0] op, input logic [4:0] r_d, input logic [4:0] r_s1,
                               input logic [4:0] r_s2, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] im, input logic il);
      exp_t e;
      e = '{op: op, rd: r_d, rs1: r_s1, rs2: r_s2, f3: f3, f7: f7, imm: im, pc: 32'h0, ill: il};
      return e;
   endfunction

   // Reference decode: pick class, field usage and immediate format, then build fields arithmetically
   function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                       input bit en_m, input bit en_f);
      exp_t e;
      int   s, im, fmt;
      bit   urd, urs1, urs2, uf3, uf7, bad;
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = w[14:12];
      f7 = w[31:25];
      e = '0;
      s = w;
      im = 0;
      fmt = 0;
      {urd, urs1, urs2, uf3, uf7, bad} = '0;
      case (w[6:0])
         7'h37: begin e.op = T_LUI;   urd = 1; fmt = 5; end
         7'h17: begin e.op = T_AUIPC; urd = 1; fmt = 5; end
         7'h6F: begin e.op = T_JAL;   urd = 1; fmt = 4; end
         7'h67: begin e.op = T_JALR;  urd = 1; urs1 = 1; uf3 = 1; fmt = 1; bad = (f3 != 0); end
         7'h63: begin e.op = T_BRANCH; urs1 = 1; urs2 = 1; uf3 = 1; fmt = 3; bad = (f3 == 2 || f3 == 3); end
         7'h03: begin e.op = T_LOAD;  urd = 1; urs1 = 1; uf3 = 1; fmt = 1; bad = (f3 == 3 || f3 == 6 || f3 == 7); end
         7'h23: begin e.op = T_STORE; urs1 = 1; urs2 = 1; uf3 = 1; fmt = 2; bad = (f3 > 2); end
         7'h13: begin
            e.op = T_OPIMM; urd = 1; urs1 = 1; uf3 = 1; fmt = 1;
            if (f3 == 1 || f3 == 5) begin
               uf7 = 1;
               bad = !(f7 == 0 || (f3 == 5 && f7 == 7'h20));
            end
         end
         7'h33: begin
            e.op = T_OP; urd = 1; urs1 = 1; urs2 = 1; uf3 = 1; uf7 = 1;
            bad = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (f7 == 1 && en_m));
         end
         7'h0F: begin e.op = T_MISCMEM; urd = 1; urs1 = 1; uf3 = 1; bad = !en_f; end
         7'h73: begin e.op = T_SYSTEM;  urd = 1; urs1 = 1; uf3 = 1; end
         default: bad = 1;
      endcase
      if (w[1:0] != 2'b11) bad = 1;
      case (fmt)
         1: im = s >>> 20;
         2: im = ((s >>> 25) <<< 5) | int'(w[11:7]);
         3: im = ((s >>> 31) <<< 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5) | (int'(w[11:8]) << 1);
         4: im = ((s >>> 31) <<< 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11) | (int'(w[30:21]) << 1);
         5: im = s & 32'hFFFFF000;
         default: im = 0;
      endcase
      e.imm = im;
      e.rd  = urd  ? w[11:7]  : 5'd0;
      e.rs1 = urs1 ? w[19:15] : 5'd0;
      e.rs2 = urs2 ? w[24:20] : 5'd0;
      e.f3  = uf3  ? f3 : 3'd0;
      e.f7  = uf7  ? f7 : 7'd0;
      if (bad) begin
         e = '0;
         e.op = T_SYSTEM;
         e.ill = 1'b1;
      end
      e.pc = pc;
      return e;
   endfunction

   vec_t vecs[18];
   logic [6:0] opcs[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
   exp_t q[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{32'h00500093, mk(T_OPIMM, 1, 0, 0, 0, 0, 32'h5, 0), 1'b0};
      vecs[1]  = '{32'h12345137, mk(T_LUI, 2, 0, 0, 0, 0, 32'h12345000, 0), 1'b0};
      vecs[2]  = '{32'h022081B3, mk(T_OP, 3, 1, 2, 0, 7'h01, 32'h0, 0), 1'b1};
      vecs[3]  = '{32'h00000000, mk(T_SYSTEM, 0, 0, 0, 0, 0, 32'h0, 1), 1'b1};
      vecs[4]  = '{32'h0000007F, mk(T_SYSTEM, 0, 0, 0, 0, 0, 32'h0, 1), 1'b1};
      vecs[5]  = '{32'h407302B3, mk(T_OP, 5, 6, 7, 0, 7'h20, 32'h0, 0), 1'b0};
      vecs[6]  = '{32'h407312B3, mk(T_SYSTEM, 0, 0, 0, 0, 0, 32'h0, 1), 1'b1};
      vecs[7]  = '{32'hFE208EE3, mk(T_BRANCH, 0, 1, 2, 0, 0, 32'hFFFFFFFC, 0), 1'b0};
      vecs[8]  = '{32'h008000EF, mk(T_JAL, 1, 0, 0, 0, 0, 32'h8, 0), 1'b0};
      vecs[9]  = '{32'hFE512A23, mk(T_STORE, 0, 2, 5, 2, 0, 32'hFFFFFFF4, 0), 1'b0};
      vecs[10] = '{32'h000090E7, mk(T_SYSTEM, 0, 0, 0, 0, 0, 32'h0, 1), 1'b1};
      vecs[11] = '{32'h4030D093, mk(T_OPIMM, 1, 1, 0, 5, 7'h20, 32'h403, 0), 1'b0};
      vecs[12] = '{32'h0FF0000F, mk(T_MISCMEM, 0, 0, 0, 0, 0, 32'h0, 0), 1'b1};
      vecs[13] = '{32'h80000217, mk(T_AUIPC, 4, 0, 0, 0, 0, 32'h80000000, 0), 1'b0};
      vecs[14] = '{32'h00000073, mk(T_SYSTEM, 0, 0, 0, 0, 0, 32'h0, 0), 1'b0};
      vecs[15] = '{32'h00003083, mk(T_SYSTEM, 0, 0, 0, 0, 0, 32'h0, 1), 1'b1};
      vecs[16] = '{32'h40309093, mk(T_SYSTEM, 0, 0, 0, 0, 0, 32'h0, 1), 1'b1};
      vecs[17] = '{32'h00000031, mk(T_SYSTEM, 0, 0, 0, 0, 0, 32'h0, 1), 1'b1};

      // reset state
      #12;
      check("reset_out_valid", 128'(out_valid), 128'(1'b0));
      check("reset_in_ready", 128'(in_ready), 128'(1'b1));
      check("reset_bundle", 128'(dut_bundle()), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // directed decode table, streamed back-to-back with out_ready=1
      out_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (i > 0) begin
            exp_t e;
            e = vecs[i-1].e;
            e.pc = 32'h1000 + 32'((i - 1) * 4);
            check("vec_valid", 128'(out_valid), 128'(1'b1));
            check($sformatf("vec%0d_bundle", i - 1), 128'(dut_bundle()), 128'(e));
            check($sformatf("vec%0d_ill_m0", i - 1), 128'(m0_illegal), 128'(vecs[i-1].ill_m0));
         end
         in_valid = 1'b1;
         instr = vecs[i].w;
         in_pc = 32'h1000 + 32'(i * 4);
      end
      @(negedge clk);
      in_valid = 1'b0;
      begin
         exp_t e;
         e = vecs[17].e;
         e.pc = 32'h1000 + 32'(17 * 4);
         check("vec17_bundle", 128'(dut_bundle()), 128'(e));
      end
      @(negedge clk);
      check("drain_out_valid", 128'(out_valid), 128'(1'b0));

      // backpressure: three instructions, consumer stalled for the first cycles
      begin
         logic [31:0] ws[3];
         int sent, got;
         ws[0] = 32'h00500093; ws[1] = 32'h12345137; ws[2] = 32'h022081B3;
         sent = 0; got = 0;
         out_ready = 1'b0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 2) check("bp_in_ready_after2", 128'(in_ready), 128'(1'b0));
            if (c == 3) begin
               check("bp_in_ready_stall", 128'(in_ready), 128'(1'b0));
               check("bp_hold_pc", 128'(out_pc), 128'(32'h2000));
            end
            if (c == 4) out_ready = 1'b1;
            if (out_valid && out_ready) begin
               if (got < 3)
                  check($sformatf("bp_order%0d", got), 128'(dut_bundle()),
                        128'(ref_decode(ws[got], 32'h2000 + 32'(got * 4), 1, 1)));
               else
                  check("bp_extra_bundle", 128'(got), 128'(2));
               got++;
            end
            if (sent < 3 && in_ready) begin
               in_valid = 1'b1;
               instr = ws[sent];
               in_pc = 32'h2000 + 32'(sent * 4);
               sent++;
            end else begin
               in_valid = 1'b0;
            end
         end
         check("bp_delivered", 128'(got), 128'(3));
      end

      // flush with two held (in_ready low) and with one held (in_ready high) plus an input
      for (int v = 0; v < 2; v++) begin
         int seen;
         seen = 0;
         out_ready = 1'b0;
         for (int k = 0; k < 2 - v; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            instr = 32'h00100093 + 32'(k << 7);
            in_pc = 32'h3000 + 32'(k * 4);
         end
         @(negedge clk);
         in_valid = 1'b1;
         instr = 32'h00700113;
         in_pc = 32'h3100;
         flush = 1'b1;
         @(negedge clk);
         flush = 1'b0;
         in_valid = 1'b0;
         check($sformatf("flush%0d_out_valid", v), 128'(out_valid), 128'(1'b0));
         check($sformatf("flush%0d_in_ready", v), 128'(in_ready), 128'(1'b1));
         out_ready = 1'b1;
         for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
         end
         check($sformatf("flush%0d_nothing_appears", v), 128'(seen), 128'(0));
      end

      // randomized traffic against the queue model
      q.delete();
      for (int c = 0; c < 3000; c++) begin
         logic [31:0] w;
         bit inf, outf;
         @(negedge clk);
         w = $urandom;
         if ($urandom_range(3) != 0) w[6:0] = opcs[$urandom_range(10)];
         case ($urandom_range(3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
         endcase
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         flush     = ($urandom_range(40) == 0);
         instr     = w;
         in_pc     = $urandom;
         check("rnd_out_valid", 128'(out_valid), 128'(q.size() > 0));
         check("rnd_in_ready", 128'(in_ready), 128'(q.size() < 2));
         inf  = in_valid && in_ready && !flush;
         outf = out_valid && out_ready;
         if (outf && q.size() > 0) check("rnd_bundle", 128'(dut_bundle()), 128'(q[0]));
         if (flush) begin
            q.delete();
         end else begin
            if (outf && q.size() > 0) void'(q.pop_front());
            if (inf) q.push_back(ref_decode(instr, in_pc, 1, 1));
         end
      end

      // asynchronous reset mid-operation
      @(negedge clk);
      flush = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      instr = 32'h12345137;
      in_pc = 32'h4000;
      @(negedge clk);
      in_valid = 1'b0;
      check("prereset_out_valid", 128'(out_valid), 128'(1'b1));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_out_valid", 128'(out_valid), 128'(1'b0));
      check("async_reset_in_ready", 128'(in_ready), 128'(1'b1));
      check("async_reset_bundle", 128'(dut_bundle()), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
